// File: rtl/move_request_ctrl.sv
// move_request_ctrl: collects from/to squares, resolves the moving piece slot and hands the
// move to the board update stage. Optional feature macro: MOVE_REQ_OWN_CAPTURE_CHECK_EN.
module move_request_ctrl #(
  parameter int unsigned DONE_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        sq_valid,
  input  logic [5:0]  sq,
  input  logic        cancel,
  input  logic        player,
  input  logic [95:0] location_vectors_w,
  input  logic [95:0] location_vectors_b,
  input  logic [15:0] alive_vectors_w,
  input  logic [15:0] alive_vectors_b,
  input  logic        upd_done,
  output logic        upd_en,
  output logic [3:0]  piece_number,
  output logic [5:0]  move_input,
  output logic        move_player,
  output logic        busy,
  output logic        move_ok,
  output logic        err_valid,
  output logic [2:0]  err_code,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    StWaitFrom = 3'd0,
    StScanFrom = 3'd1,
    StWaitTo   = 3'd2,
    StScanTo   = 3'd3,
    StIssue    = 3'd4,
    StWaitDone = 3'd5
  } state_e;

  localparam logic [2:0] ErrNone     = 3'd0;
  localparam logic [2:0] ErrNoPiece  = 3'd1;
  localparam logic [2:0] ErrNullMove = 3'd3;
  localparam logic [2:0] ErrTimeout  = 3'd4;
`ifdef MOVE_REQ_OWN_CAPTURE_CHECK_EN
  localparam logic [2:0] ErrOwnCapture = 3'd2;
  logic [5:0] to_sq_q, to_sq_d;
`endif

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       found_q, found_d;
  logic [5:0] from_sq_q, from_sq_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic [3:0] piece_q, piece_d;
  logic [5:0] move_input_q, move_input_d;
  logic       move_player_q, move_player_d;
  logic       upd_en_q, upd_en_d;
  logic       busy_q, busy_d;
  logic       move_ok_q, move_ok_d;
  logic       err_valid_q, err_valid_d;
  logic [2:0] err_code_q, err_code_d;

  // Slot currently under the scan counter, taken from the side latched at from-capture.
  logic [95:0] loc_vec;
  logic [15:0] alive_vec;
  logic [5:0]  slot_loc [16];
  logic [5:0]  cur_loc;
  logic        cur_alive;

  always_comb begin
    loc_vec   = move_player_q ? location_vectors_w : location_vectors_b;
    alive_vec = move_player_q ? alive_vectors_w : alive_vectors_b;
    for (int i = 0; i < 16; i++) begin
      slot_loc[i] = loc_vec[6*i +: 6];
    end
  end

  assign cur_loc   = slot_loc[cnt_q];
  assign cur_alive = alive_vec[cnt_q];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    found_d       = found_q;
    from_sq_d     = from_sq_q;
    tcnt_d        = tcnt_q;
    piece_d       = piece_q;
    move_input_d  = move_input_q;
    move_player_d = move_player_q;
    upd_en_d      = 1'b0;
    move_ok_d     = 1'b0;
    err_valid_d   = 1'b0;
    err_code_d    = err_code_q;
`ifdef MOVE_REQ_OWN_CAPTURE_CHECK_EN
    to_sq_d       = to_sq_q;
`endif
    unique case (state_q)
      StWaitFrom: begin
        if (sq_valid) begin
          from_sq_d     = sq;
          move_player_d = player;
          err_code_d    = ErrNone;
          cnt_d         = 4'd15;
          found_d       = 1'b0;
          state_d       = StScanFrom;
        end
      end
      StScanFrom: begin
        if (cancel) begin
          state_d = StWaitFrom;
        end else begin
          // Highest-index hit wins; later hits are ignored once found is set.
          if (cur_alive && (cur_loc == from_sq_q) && !found_q) begin
            piece_d = cnt_q;
            found_d = 1'b1;
          end
          if (cnt_q == 4'd0) begin
            if (found_q || (cur_alive && (cur_loc == from_sq_q))) begin
              state_d = StWaitTo;
            end else begin
              err_valid_d = 1'b1;
              err_code_d  = ErrNoPiece;
              state_d     = StWaitFrom;
            end
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      StWaitTo: begin
        if (cancel) begin
          state_d = StWaitFrom;
        end else if (sq_valid) begin
          if (sq == from_sq_q) begin
            err_valid_d = 1'b1;
            err_code_d  = ErrNullMove;
            state_d     = StWaitFrom;
          end else begin
`ifdef MOVE_REQ_OWN_CAPTURE_CHECK_EN
            to_sq_d = sq;
            cnt_d   = 4'd15;
            found_d = 1'b0;
            state_d = StScanTo;
`else
            move_input_d = sq;
            upd_en_d     = 1'b1;
            tcnt_d       = 8'd0;
            state_d      = StIssue;
`endif
          end
        end
      end
`ifdef MOVE_REQ_OWN_CAPTURE_CHECK_EN
      StScanTo: begin
        if (cancel) begin
          state_d = StWaitFrom;
        end else begin
          if (cur_alive && (cur_loc == to_sq_q)) begin
            found_d = 1'b1;
          end
          if (cnt_q == 4'd0) begin
            if (found_q || (cur_alive && (cur_loc == to_sq_q))) begin
              err_valid_d = 1'b1;
              err_code_d  = ErrOwnCapture;
              state_d     = StWaitFrom;
            end else begin
              move_input_d = to_sq_q;
              upd_en_d     = 1'b1;
              tcnt_d       = 8'd0;
              state_d      = StIssue;
            end
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
`endif
      StIssue: begin
        tcnt_d  = 8'd0;
        state_d = StWaitDone;
      end
      StWaitDone: begin
        if (upd_done) begin
          move_ok_d = 1'b1;
          state_d   = StWaitFrom;
        end else if (tcnt_q + 8'd1 == 8'(DONE_TIMEOUT)) begin
          err_valid_d = 1'b1;
          err_code_d  = ErrTimeout;
          state_d     = StWaitFrom;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      default: state_d = StWaitFrom;
    endcase
    busy_d = !((state_d == StWaitFrom) || (state_d == StWaitTo));
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q       <= StWaitFrom;
      cnt_q         <= 4'd0;
      found_q       <= 1'b0;
      from_sq_q     <= 6'd0;
      tcnt_q        <= 8'd0;
      piece_q       <= 4'd0;
      move_input_q  <= 6'd0;
      move_player_q <= 1'b1;
      upd_en_q      <= 1'b0;
      busy_q        <= 1'b0;
      move_ok_q     <= 1'b0;
      err_valid_q   <= 1'b0;
      err_code_q    <= ErrNone;
`ifdef MOVE_REQ_OWN_CAPTURE_CHECK_EN
      to_sq_q       <= 6'd0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      found_q       <= found_d;
      from_sq_q     <= from_sq_d;
      tcnt_q        <= tcnt_d;
      piece_q       <= piece_d;
      move_input_q  <= move_input_d;
      move_player_q <= move_player_d;
      upd_en_q      <= upd_en_d;
      busy_q        <= busy_d;
      move_ok_q     <= move_ok_d;
      err_valid_q   <= err_valid_d;
      err_code_q    <= err_code_d;
`ifdef MOVE_REQ_OWN_CAPTURE_CHECK_EN
      to_sq_q       <= to_sq_d;
`endif
    end
  end

  assign upd_en       = upd_en_q;
  assign piece_number = piece_q;
  assign move_input   = move_input_q;
  assign move_player  = move_player_q;
  assign busy         = busy_q;
  assign move_ok      = move_ok_q;
  assign err_valid    = err_valid_q;
  assign err_code     = err_code_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_move_request_ctrl.sv
// Bench for move_request_ctrl: directed plan items followed by randomized moves, all
// checked against a square-level reference model of the request flow.
module tb_move_request_ctrl;

  localparam int unsigned T = 8;
  localparam int W = 50;
`ifdef MOVE_REQ_OWN_CAPTURE_CHECK_EN
  localparam bit OwnChk = 1'b1;
`else
  localparam bit OwnChk = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        RST, sq_valid, cancel, player, upd_done;
  logic [5:0]  sq;
  logic [95:0] lvw, lvb;
  logic [15:0] avw, avb;
  logic        upd_en, move_player, busy, move_ok, err_valid;
  logic [3:0]  piece_number;
  logic [5:0]  move_input;
  logic [2:0]  err_code, dbg_state;

  int wloc [16];
  int bloc [16];
  int checks = 0;
  int failures = 0;
  int prev_err = 0;

  move_request_ctrl #(.DONE_TIMEOUT(T)) dut (
    .clk(clk), .RST(RST), .sq_valid(sq_valid), .sq(sq), .cancel(cancel), .player(player),
    .location_vectors_w(lvw), .location_vectors_b(lvb),
    .alive_vectors_w(avw), .alive_vectors_b(avb),
    .upd_done(upd_done), .upd_en(upd_en), .piece_number(piece_number),
    .move_input(move_input), .move_player(move_player), .busy(busy), .move_ok(move_ok),
    .err_valid(err_valid), .err_code(err_code), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always_comb begin
    lvw = '0;
    lvb = '0;
    for (int i = 0; i < 16; i++) begin
      lvw[6*i +: 6] = 6'(wloc[i]);
      lvb[6*i +: 6] = 6'(bloc[i]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic init_board();
    int sq_of [8] = '{4, 3, 0, 7, 1, 6, 2, 5};
    for (int i = 0; i < 16; i++) begin
      wloc[i] = (i < 8) ? sq_of[i] : 23 - i;
      bloc[i] = wloc[i] + 48;
    end
    avw = 16'hFFFF;
    avb = 16'hFFFF;
  endtask

  // Reference: highest alive slot of the side standing on square s, or -1.
  function automatic int find_piece(input int s, input bit pl);
    for (int i = 15; i >= 0; i--) begin
      if ((pl ? avw[i] : avb[i]) && ((pl ? wloc[i] : bloc[i]) == s)) return i;
    end
    return -1;
  endfunction

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_state"}, dbg_state, 0);
    check({pfx, "_piece"}, piece_number, 0);
    check({pfx, "_move_input"}, move_input, 0);
    check({pfx, "_move_player"}, move_player, 1);
    check({pfx, "_upd_en"}, upd_en, 0);
    check({pfx, "_move_ok"}, move_ok, 0);
    check({pfx, "_err_valid"}, err_valid, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_err_code"}, err_code, 0);
  endtask

  // One request; d = cycles from upd_en to upd_done (0 = never), c = cancel cycle (0 = none).
  // Cycle indices count from the cycle sq_valid carries the from-square.
  task automatic run_txn(input string tag, input logic [5:0] from, input logic [5:0] to,
                         input bit pl, input int d, input int c);
    int p, k_exp, err_exp, err_n_exp, ok_n_exp;
    bit send_to;
    int upd_n, upd_cnt, err_n, err_cnt, ok_n, ok_cnt;
    logic [3:0] pn;
    logic [5:0] mi;
    logic mp;
    p = find_piece(int'(from), pl);
    err_exp = 0; err_n_exp = -1; k_exp = -1; ok_n_exp = -1;
    send_to = (p >= 0) && !(c >= 1 && c <= 16);
    if (p < 0) begin
      if (!(c >= 1 && c <= 16)) begin err_exp = 1; err_n_exp = 17; end
    end else if (c >= 1 && c <= 17) begin
      err_exp = 0;
    end else if (to == from) begin
      err_exp = 3; err_n_exp = 18;
    end else if (OwnChk && c >= 18 && c <= 33) begin
      err_exp = 0;
    end else if (OwnChk && find_piece(int'(to), pl) >= 0) begin
      err_exp = 2; err_n_exp = 34;
    end else begin
      k_exp = OwnChk ? 34 : 18;
      if (d >= 1 && d <= int'(T)) ok_n_exp = k_exp + d + 1;
      else begin err_exp = 4; err_n_exp = k_exp + int'(T) + 1; end
    end

    check({tag, "_err_hold"}, err_code, prev_err);
    player = pl; sq = from; sq_valid = 1'b1; cancel = 1'b0; upd_done = 1'b0;
    upd_n = -1; upd_cnt = 0; err_n = -1; err_cnt = 0; ok_n = -1; ok_cnt = 0;
    pn = '0; mi = '0; mp = 1'b0;
    for (int n = 1; n <= W; n++) begin
      step();
      if (n == 1) begin
        check({tag, "_busy_scan"}, busy, 1);
        check({tag, "_err_clr"}, err_code, 0);
      end
      if (upd_en) begin
        upd_cnt++;
        if (upd_n < 0) begin
          upd_n = n; pn = piece_number; mi = move_input; mp = move_player;
        end
      end
      if (err_valid) begin err_cnt++; err_n = n; end
      if (move_ok) begin ok_cnt++; ok_n = n; end
      sq_valid = 1'b0; cancel = (n == c); upd_done = (n == 3);
      player = 1'($urandom); sq = 6'($urandom);
      if (n == 5 && c == 0) sq_valid = 1'b1;
      if (n == 17 && send_to) begin sq_valid = 1'b1; sq = to; end
      if (upd_n > 0 && d > 0 && n == upd_n + d) upd_done = 1'b1;
    end
    check({tag, "_err_pulses"}, err_cnt, (err_exp != 0) ? 1 : 0);
    check({tag, "_err_cycle"}, err_n, err_n_exp);
    check({tag, "_err_code"}, err_code, err_exp);
    check({tag, "_upd_pulses"}, upd_cnt, (k_exp >= 0) ? 1 : 0);
    check({tag, "_upd_cycle"}, upd_n, k_exp);
    check({tag, "_ok_pulses"}, ok_cnt, (ok_n_exp >= 0) ? 1 : 0);
    check({tag, "_ok_cycle"}, ok_n, ok_n_exp);
    if (k_exp >= 0) begin
      check({tag, "_piece"}, pn, p);
      check({tag, "_move_input"}, mi, to);
      check({tag, "_move_player"}, mp, pl);
    end
    check({tag, "_idle_state"}, dbg_state, 0);
    check({tag, "_idle_busy"}, busy, 0);
    prev_err = err_exp;
  endtask

  initial begin
    int k, seen_k, cnt_upd, cnt_ok;
    logic [5:0] f, t;
    bit pl;
    init_board();
    RST = 1'b1; sq_valid = 1'b0; cancel = 1'b0; player = 1'b1; upd_done = 1'b0; sq = '0;
    step();
    step();
    check_reset_outputs("reset");
    RST = 1'b0;
    step();
    check_reset_outputs("post_reset");

    run_txn("pawn_move", 6'd8, 6'd16, 1'b1, 3, 0);
    run_txn("empty_from", 6'd20, 6'd28, 1'b1, 3, 0);
    avw[15] = 1'b0;
    run_txn("dead_from", 6'd8, 6'd16, 1'b1, 3, 0);
    avw[15] = 1'b1;
    run_txn("own_capture", 6'd3, 6'd4, 1'b1, 3, 0);
    run_txn("null_move", 6'd9, 6'd9, 1'b1, 3, 0);
    run_txn("timeout", 6'd8, 6'd16, 1'b1, 0, 0);
    run_txn("black_move", 6'd55, 6'd47, 1'b0, 2, 0);
    run_txn("cancel_scan", 6'd12, 6'd20, 1'b1, 3, OwnChk ? 25 : 10);
    run_txn("cancel_prio", 6'd12, 6'd20, 1'b1, 3, 17);
    run_txn("late_done", 6'd10, 6'd18, 1'b1, int'(T), 0);

    // Reset while waiting for done: request is dropped and never issued again.
    k = OwnChk ? 34 : 18;
    seen_k = -1;
    player = 1'b1; sq = 6'd8; sq_valid = 1'b1;
    for (int n = 1; n <= k + 2; n++) begin
      step();
      if (upd_en && seen_k < 0) seen_k = n;
      sq_valid = (n == 17);
      sq = 6'd16;
    end
    check("rst_upd_seen", seen_k, k);
    RST = 1'b1;
    step();
    check_reset_outputs("rst_mid");
    RST = 1'b0; upd_done = 1'b1;
    cnt_upd = 0; cnt_ok = 0;
    for (int n = 0; n < 20; n++) begin
      step();
      upd_done = 1'b0;
      if (upd_en) cnt_upd++;
      if (move_ok) cnt_ok++;
    end
    check("rst_no_upd", cnt_upd, 0);
    check("rst_no_ok", cnt_ok, 0);
    prev_err = 0;

    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 16; i++) begin
        wloc[i] = int'($urandom_range(0, 63));
        bloc[i] = int'($urandom_range(0, 63));
      end
      avw = 16'($urandom);
      avb = 16'($urandom);
      pl = 1'($urandom);
      if ($urandom_range(0, 1) == 1) f = 6'(pl ? wloc[$urandom_range(0, 15)] : bloc[$urandom_range(0, 15)]);
      else f = 6'($urandom);
      case ($urandom_range(0, 7))
        0: t = f;
        1, 2: t = 6'(pl ? wloc[$urandom_range(0, 15)] : bloc[$urandom_range(0, 15)]);
        default: t = 6'($urandom);
      endcase
      run_txn("rand", f, t, pl, int'($urandom_range(0, T)),
              ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 40)) : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
